p2s_serializer: RTL and testbench
=================================

# p2s_serializer

Parametrised parallel-to-serial converter with a valid/ready word input, a one-word holding buffer for gap-free back-to-back words, an external bit-rate enable, selectable bit order and a programmable idle line level. It sits between a word producer (CPU I/O register or FIFO) and a serial line driver such as a UART TX framer or SPI MOSI. It replaces bare parallel-load shift registers where flow control and word boundaries are needed.

## Interface
Parameters:
- W, 8: word width in bits; must be ≥ 2.
- MSB_FIRST, 0: 0 shifts bit 0 out first; 1 shifts bit W-1 out first.
- IDLE_LEVEL, 1'b1: line level driven on sout when no word is shifting; also the fill bit shifted into the vacated end of the register.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- abort  input  1  synchronous clear of the current word and the hold buffer.
- in_valid  input  1  in_data holds a word.
- in_ready  output  1  the hold buffer is empty, so the word is accepted.
- in_data  input  W  parallel word.
- shift_en  input  1  bit-rate tick; one bit advances per edge with shift_en=1.
- sout  output  1  serial data.
- sout_valid  output  1  sout carries a data bit.
- last  output  1  sout carries the final bit of the current word.
- word_done  output  1  single-cycle pulse on the cycle the final bit is consumed.

## Operation
- State: state ∈ {IDLE, SHIFT}, sr[W-1:0], cnt[$clog2(W)-1:0], hbuf[W-1:0], hvalid.
- in_ready = ~hvalid (combinational). An accept is an edge with in_valid & in_ready: hbuf ← in_data, hvalid ← 1.
- Load condition: hvalid & (state==IDLE | (state==SHIFT & shift_en & cnt==W-1)). On load: sr ← hbuf, cnt ← 0, state ← SHIFT, hvalid ← 0. No accept can coincide with a load, because in_ready=0 whenever hvalid=1.
- SHIFT, shift_en=1, cnt<W-1: cnt ← cnt+1. LSB-first: sr ← {IDLE_LEVEL, sr[W-1:1]}. MSB-first: sr ← {sr[W-2:0], IDLE_LEVEL}.
- SHIFT, shift_en=1, cnt==W-1: word ends. If hvalid, load; otherwise state ← IDLE, cnt ← 0.
- SHIFT, shift_en=0: sr and cnt hold.
- sout = IDLE_LEVEL in IDLE. In SHIFT, sout = sr[0] (LSB-first) or sr[W-1] (MSB-first).
- sout_valid = (state==SHIFT).
- last = (state==SHIFT & cnt==W-1).
- word_done = last & shift_en (combinational).
- abort=1 at an edge: state ← IDLE, cnt ← 0, hvalid ← 0, sr ← 0. Abort overrides load, shift and accept; a word offered in the same cycle is dropped even though in_ready was 1.
- Reset (rst=0, asynchronous): state=IDLE, sr=0, cnt=0, hbuf=0, hvalid=0. During and after reset: sout=IDLE_LEVEL, sout_valid=0, last=0, word_done=0, in_ready=1. A reset mid-word discards both the current word and the held word.

## Timing
- Accept at the edge ending cycle c. The load happens at the edge ending cycle c+1. The first bit appears on sout in cycle c+2, independent of shift_en.
- Each bit stays on sout until an edge with shift_en=1. With shift_en tied high, bit i is on sout in cycle c+2+i, and word_done pulses in cycle c+1+W.
- Back-to-back: if the next word is in hbuf before the final-bit edge, its bit 0 follows the previous bit W-1 with zero gap. sout_valid stays high.
- in_ready returns to 1 in the cycle after a load. For a continuous stream the producer therefore has W shift_en periods to present the next word.
- Wrap-around: cnt counts 0..W-1 only and never exceeds W-1. This holds for non-power-of-two W.

## Test plan
- Reset: assert rst=0 mid-word with hvalid=1, W=8, IDLE_LEVEL=1 -> sout=1, sout_valid=0, in_ready=1 immediately (asynchronously). No bits resume after release.
- Single word: LSB-first, W=8, shift_en=1, accept 0xA5 in cycle 0 -> sout 1,0,1,0,0,1,0,1 in cycles 2–9. last and word_done in cycle 9. sout=1 and sout_valid=0 from cycle 10.
- MSB-first, W=5: accept 5'b10011 -> sout 1,0,0,1,1. Same word with shift_en high every 3rd cycle -> each bit is held for exactly 3 cycles.
- Back-to-back: LSB-first, W=8, accept 0x0F then 0xF0 while the first is shifting -> 16 contiguous bits 1111000000001111. sout_valid high throughout. in_ready low from the second accept until cycle 10.
- Abort: abort in cycle 5 of a word with hvalid=1 and in_valid=1 -> cycle 6 shows IDLE, hvalid=0, in_ready=1. The concurrent word is dropped and there is no word_done.
- Sweep: W ∈ {2,3,8,13}, both bit orders, random words and random shift_en -> a scoreboard matches every emitted word. word_done count equals accepted count minus aborted words.

Source files
------------

// File: rtl/p2s_serializer_if.sv
// Word-in / bit-out bus of the parallel-to-serial converter, with producer (master) and serializer (slave) views.
interface p2s_serializer_if #(
  parameter int W = 8
);
  logic         abort;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         shift_en;
  logic         sout;
  logic         sout_valid;
  logic         last;
  logic         word_done;

  modport master (
    output abort, in_valid, in_data, shift_en,
    input  in_ready, sout, sout_valid, last, word_done
  );

  modport slave (
    input  abort, in_valid, in_data, shift_en,
    output in_ready, sout, sout_valid, last, word_done
  );
endinterface

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter with a one-word hold buffer; first bit reaches sout two cycles after accept.
// in_ready drops while a word waits in the hold buffer; bits advance only on edges with shift_en high.
module p2s_serializer #(
  parameter int   W          = 8,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  p2s_serializer_if.slave bus
);
  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  sr, sr_nxt;
  logic [W-1:0]  hbuf, hbuf_nxt;
  logic [W-1:0]  sr_shifted;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          hvalid, hvalid_nxt;
  logic          at_last;
  logic          accept;
  logic          load;

  // The vacated end of the register is refilled with the idle level.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shifted = {sr[W-2:0], IDLE_LEVEL};
    end else begin : g_lsb_first
      assign sr_shifted = {IDLE_LEVEL, sr[W-1:1]};
    end
  endgenerate

  assign at_last = (state == SHIFT) && (cnt == CNT_LAST);
  assign accept  = bus.in_valid && !hvalid;
  // Loading on the final-bit edge is what makes back-to-back words gap-free.
  assign load    = hvalid && ((state == IDLE) || (at_last && bus.shift_en));

  always_comb begin
    state_nxt  = state;
    sr_nxt     = sr;
    cnt_nxt    = cnt;
    hbuf_nxt   = hbuf;
    hvalid_nxt = hvalid;
    if (bus.abort) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      hvalid_nxt = 1'b0;
      sr_nxt     = '0;
    end else begin
      if (accept) begin
        hbuf_nxt   = bus.in_data;
        hvalid_nxt = 1'b1;
      end
      if (load) begin
        sr_nxt     = hbuf;
        cnt_nxt    = '0;
        state_nxt  = SHIFT;
        hvalid_nxt = 1'b0;
      end else if ((state == SHIFT) && bus.shift_en) begin
        if (at_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
          sr_nxt  = sr_shifted;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      hbuf   <= '0;
      hvalid <= 1'b0;
    end else begin
      state  <= state_nxt;
      sr     <= sr_nxt;
      cnt    <= cnt_nxt;
      hbuf   <= hbuf_nxt;
      hvalid <= hvalid_nxt;
    end
  end

  assign bus.in_ready   = ~hvalid;
  assign bus.sout       = (state == SHIFT) ? (MSB_FIRST ? sr[W-1] : sr[0]) : IDLE_LEVEL;
  assign bus.sout_valid = (state == SHIFT);
  assign bus.last       = at_last;
  assign bus.word_done  = at_last && bus.shift_en;
endmodule

// File: tb/tb_p2s_serializer.sv
// Bench for p2s_serializer: directed scenarios on W=8 and W=5 instances, then a randomized sweep of nine instances.
module tb_p2s_serializer;
  localparam int NI = 9;
  localparam int D8 = 4;  // W=8, LSB-first, idle high
  localparam int D5 = 8;  // W=5, MSB-first, idle high

  function automatic int sw_w(input int g);
    case (g)
      0, 1:    return 2;
      2, 3:    return 3;
      4, 5:    return 8;
      6, 7:    return 13;
      default: return 5;
    endcase
  endfunction

  function automatic bit sw_msb(input int g);
    return (g == 1) || (g == 3) || (g == 5) || (g == 7) || (g == 8);
  endfunction

  function automatic bit sw_idle(input int g);
    return (g % 3) != 0;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sw_valid [NI];
  logic        sw_shift [NI];
  logic        sw_abort [NI];
  logic [12:0] sw_data  [NI];
  logic        sw_ready [NI];
  logic        sw_sout  [NI];
  logic        sw_sv    [NI];
  logic        sw_last  [NI];
  logic        sw_wd    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int   GW = sw_w(g);
    localparam bit   GM = sw_msb(g);
    localparam logic GI = sw_idle(g);
    p2s_serializer_if #(.W(GW)) sif ();
    p2s_serializer #(.W(GW), .MSB_FIRST(GM), .IDLE_LEVEL(GI)) u_dut (
      .clk(clk),
      .rst(rst_n),
      .bus(sif)
    );
    assign sif.in_valid = sw_valid[g];
    assign sif.in_data  = sw_data[g][GW-1:0];
    assign sif.shift_en = sw_shift[g];
    assign sif.abort    = sw_abort[g];
    assign sw_ready[g]  = sif.in_ready;
    assign sw_sout[g]   = sif.sout;
    assign sw_sv[g]     = sif.sout_valid;
    assign sw_last[g]   = sif.last;
    assign sw_wd[g]     = sif.word_done;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic idle_inputs();
    for (int i = 0; i < NI; i++) begin
      sw_valid[i] = 1'b0;
      sw_shift[i] = 1'b0;
      sw_abort[i] = 1'b0;
      sw_data[i]  = '0;
    end
  endtask

  task automatic test_reset();
    #3;
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if (sw_sout[i] !== sw_idle(i) || sw_sv[i] !== 1'b0 || sw_ready[i] !== 1'b1 ||
          sw_last[i] !== 1'b0 || sw_wd[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state inst=%0d got sout=%b sv=%b rdy=%b last=%b wd=%b exp sout=%b sv=0 rdy=1 last=0 wd=0",
                 i, sw_sout[i], sw_sv[i], sw_ready[i], sw_last[i], sw_wd[i], sw_idle(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Start a word, queue a second one, then pull reset in cycle 5.
    for (int k = 0; k < 5; k++) begin
      sw_shift[D8] = 1'b1;
      sw_valid[D8] = (k == 0) || (k == 2);
      sw_data[D8]  = (k == 0) ? 13'h03C : 13'h099;
      @(posedge clk); #1;
    end
    sw_valid[D8] = 1'b0;
    n_chk++;
    if (sw_ready[D8] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pre_hvalid got rdy=%b exp 0", sw_ready[D8]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (sw_sout[D8] !== 1'b1 || sw_sv[D8] !== 1'b0 || sw_ready[D8] !== 1'b1 ||
        sw_last[D8] !== 1'b0 || sw_wd[D8] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async got sout=%b sv=%b rdy=%b last=%b wd=%b exp 1 0 1 0 0",
               sw_sout[D8], sw_sv[D8], sw_ready[D8], sw_last[D8], sw_wd[D8]);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n_chk++;
      if (sw_sv[D8] !== 1'b0 || sw_sout[D8] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_no_resume cyc=%0d got sv=%b sout=%b exp sv=0 sout=1", k, sw_sv[D8], sw_sout[D8]);
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_single_word();
    logic [7:0] b;
    logic exp_sout, exp_sv, exp_last, exp_rdy;
    b = 8'hA5;
    for (int k = 0; k < 12; k++) begin
      sw_valid[D8] = (k == 0);
      sw_data[D8]  = 13'h0A5;
      sw_shift[D8] = 1'b1;
      @(negedge clk);
      exp_sv   = (k >= 2) && (k <= 9);
      exp_sout = 1'b1;
      if (exp_sv) exp_sout = b[k-2];
      exp_last = (k == 9);
      exp_rdy  = (k != 1);
      n_chk++;
      if (sw_sout[D8] !== exp_sout || sw_sv[D8] !== exp_sv) begin
        n_err++;
        $display("FAIL single_sout cyc=%0d got sout=%b sv=%b exp sout=%b sv=%b", k, sw_sout[D8], sw_sv[D8], exp_sout, exp_sv);
      end
      n_chk++;
      if (sw_last[D8] !== exp_last || sw_wd[D8] !== exp_last) begin
        n_err++;
        $display("FAIL single_last cyc=%0d got last=%b wd=%b exp %b", k, sw_last[D8], sw_wd[D8], exp_last);
      end
      n_chk++;
      if (sw_ready[D8] !== exp_rdy) begin
        n_err++;
        $display("FAIL single_ready cyc=%0d got %b exp %b", k, sw_ready[D8], exp_rdy);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_msb_first();
    logic [4:0] wv;
    logic exp_sout, exp_sv, exp_last, exp_wd, sh;
    int j;
    wv = 5'b10011;
    for (int k = 0; k < 9; k++) begin
      sw_valid[D5] = (k == 0);
      sw_data[D5]  = 13'h013;
      sw_shift[D5] = 1'b1;
      @(negedge clk);
      exp_sv   = (k >= 2) && (k <= 6);
      exp_sout = exp_sv ? wv[4-(k-2)] : 1'b1;
      n_chk++;
      if (sw_sout[D5] !== exp_sout || sw_sv[D5] !== exp_sv) begin
        n_err++;
        $display("FAIL msb_sout cyc=%0d got sout=%b sv=%b exp sout=%b sv=%b", k, sw_sout[D5], sw_sv[D5], exp_sout, exp_sv);
      end
      @(posedge clk); #1;
    end
    // shift_en every third cycle: each bit must sit on sout for exactly three cycles.
    for (int k = 0; k < 19; k++) begin
      sh = (k >= 4) && (k % 3 == 1);
      sw_valid[D5] = (k == 0);
      sw_shift[D5] = sh;
      @(negedge clk);
      exp_sv   = (k >= 2) && (k <= 16);
      j        = (k - 2) / 3;
      exp_sout = exp_sv ? wv[4-j] : 1'b1;
      exp_last = (k >= 14) && (k <= 16);
      exp_wd   = (k == 16);
      n_chk++;
      if (sw_sout[D5] !== exp_sout || sw_sv[D5] !== exp_sv) begin
        n_err++;
        $display("FAIL msb_slow_sout cyc=%0d got sout=%b sv=%b exp sout=%b sv=%b", k, sw_sout[D5], sw_sv[D5], exp_sout, exp_sv);
      end
      n_chk++;
      if (sw_last[D5] !== exp_last || sw_wd[D5] !== exp_wd) begin
        n_err++;
        $display("FAIL msb_slow_last cyc=%0d got last=%b wd=%b exp last=%b wd=%b", k, sw_last[D5], sw_wd[D5], exp_last, exp_wd);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    logic exp_sout, exp_sv, exp_wd, exp_rdy;
    stream = 16'hF00F;
    for (int k = 0; k < 20; k++) begin
      sw_valid[D8] = (k == 0) || (k == 2);
      sw_data[D8]  = (k == 0) ? 13'h00F : 13'h0F0;
      sw_shift[D8] = 1'b1;
      @(negedge clk);
      exp_sv   = (k >= 2) && (k <= 17);
      exp_sout = exp_sv ? stream[k-2] : 1'b1;
      exp_wd   = (k == 9) || (k == 17);
      exp_rdy  = !((k == 1) || ((k >= 3) && (k <= 9)));
      n_chk++;
      if (sw_sout[D8] !== exp_sout || sw_sv[D8] !== exp_sv) begin
        n_err++;
        $display("FAIL b2b_sout cyc=%0d got sout=%b sv=%b exp sout=%b sv=%b", k, sw_sout[D8], sw_sv[D8], exp_sout, exp_sv);
      end
      n_chk++;
      if (sw_wd[D8] !== exp_wd || sw_last[D8] !== exp_wd) begin
        n_err++;
        $display("FAIL b2b_done cyc=%0d got wd=%b last=%b exp %b", k, sw_wd[D8], sw_last[D8], exp_wd);
      end
      n_chk++;
      if (sw_ready[D8] !== exp_rdy) begin
        n_err++;
        $display("FAIL b2b_ready cyc=%0d got %b exp %b", k, sw_ready[D8], exp_rdy);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    logic [7:0] b;
    b = 8'h5A;
    for (int k = 0; k < 21; k++) begin
      sw_shift[D8] = 1'b1;
      sw_valid[D8] = (k == 0) || (k == 2) || (k == 5) || (k == 7);
      sw_abort[D8] = (k == 5) || (k == 7);
      case (k)
        0:       sw_data[D8] = 13'h05A;
        2:       sw_data[D8] = 13'h0C3;
        5:       sw_data[D8] = 13'h077;
        default: sw_data[D8] = 13'h011;
      endcase
      @(negedge clk);
      if (k >= 2 && k <= 5) begin
        n_chk++;
        if (sw_sv[D8] !== 1'b1 || sw_sout[D8] !== b[k-2]) begin
          n_err++;
          $display("FAIL abort_pre cyc=%0d got sv=%b sout=%b exp sv=1 sout=%b", k, sw_sv[D8], sw_sout[D8], b[k-2]);
        end
      end
      if (k >= 6) begin
        n_chk++;
        if (sw_sv[D8] !== 1'b0 || sw_sout[D8] !== 1'b1 || sw_ready[D8] !== 1'b1 || sw_last[D8] !== 1'b0) begin
          n_err++;
          $display("FAIL abort_idle cyc=%0d got sv=%b sout=%b rdy=%b last=%b exp 0 1 1 0",
                   k, sw_sv[D8], sw_sout[D8], sw_ready[D8], sw_last[D8]);
        end
      end
      n_chk++;
      if (sw_wd[D8] !== 1'b0) begin
        n_err++;
        $display("FAIL abort_no_done cyc=%0d got wd=%b exp 0", k, sw_wd[D8]);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  // Reference model: per instance, a queue of accepted words; the head word streams
  // bit by bit once it shows up on sout, and only the head may ever be on the line.
  logic [12:0] mq [NI][$];
  int  mpos  [NI];
  bit  mstart[NI];
  int  mwait [NI];
  int  macc  [NI];
  int  mabt  [NI];
  int  mdone [NI];

  task automatic test_sweep();
    int w, fin;
    bit msb, exp_rdy, exp_bit, exp_last, exp_wd;
    logic [12:0] hw;
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      mpos[i] = 0; mstart[i] = 1'b0; mwait[i] = 0;
      macc[i] = 0; mabt[i] = 0; mdone[i] = 0;
    end
    for (int cyc = 0; cyc < 3100; cyc++) begin
      for (int i = 0; i < NI; i++) begin
        if (cyc < 3000) begin
          sw_valid[i] = 1'($urandom_range(0, 1));
          sw_data[i]  = 13'($urandom);
          sw_abort[i] = ($urandom_range(0, 299) == 0);
          case (i % 3)
            0:       sw_shift[i] = 1'b1;
            1:       sw_shift[i] = ($urandom_range(0, 3) != 0);
            default: sw_shift[i] = ($urandom_range(0, 2) == 0);
          endcase
        end else begin
          sw_valid[i] = 1'b0;
          sw_abort[i] = 1'b0;
          sw_shift[i] = 1'b1;
        end
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        w   = sw_w(i);
        msb = sw_msb(i);
        if (!mstart[i] && sw_sv[i] === 1'b1 && mq[i].size() > 0) begin
          mstart[i] = 1'b1;
          mpos[i]   = 0;
        end
        n_chk++;
        if (sw_sv[i] !== mstart[i]) begin
          n_err++;
          $display("FAIL sweep_valid inst=%0d cyc=%0d got %b exp %b (queued=%0d)", i, cyc, sw_sv[i], mstart[i], mq[i].size());
        end
        exp_rdy = ((mq[i].size() - int'(mstart[i])) == 0);
        n_chk++;
        if (sw_ready[i] !== exp_rdy) begin
          n_err++;
          $display("FAIL sweep_ready inst=%0d cyc=%0d got %b exp %b", i, cyc, sw_ready[i], exp_rdy);
        end
        if (mstart[i]) begin
          hw       = mq[i][0];
          exp_bit  = msb ? hw[w-1-mpos[i]] : hw[mpos[i]];
          exp_last = (mpos[i] == w - 1);
        end else begin
          exp_bit  = sw_idle(i);
          exp_last = 1'b0;
        end
        exp_wd = exp_last && sw_shift[i];
        n_chk++;
        if (sw_sout[i] !== exp_bit) begin
          n_err++;
          $display("FAIL sweep_sout inst=%0d cyc=%0d got %b exp %b", i, cyc, sw_sout[i], exp_bit);
        end
        n_chk++;
        if (sw_last[i] !== exp_last || sw_wd[i] !== exp_wd) begin
          n_err++;
          $display("FAIL sweep_last inst=%0d cyc=%0d got last=%b wd=%b exp last=%b wd=%b",
                   i, cyc, sw_last[i], sw_wd[i], exp_last, exp_wd);
        end
        if (mq[i].size() > 0 && !mstart[i]) begin
          mwait[i]++;
          n_chk++;
          if (mwait[i] > 2) begin
            n_err++;
            $display("FAIL sweep_start inst=%0d cyc=%0d got wait=%0d exp <=2", i, cyc, mwait[i]);
          end
        end else begin
          mwait[i] = 0;
        end
        if (sw_wd[i] === 1'b1) mdone[i]++;
        if (sw_abort[i]) begin
          fin = (mstart[i] && sw_shift[i] && (mpos[i] == w - 1)) ? 1 : 0;
          mabt[i] += mq[i].size() - fin;
          mq[i].delete();
          mstart[i] = 1'b0;
          mpos[i]   = 0;
          mwait[i]  = 0;
        end else begin
          if (mstart[i] && sw_shift[i]) begin
            if (mpos[i] == w - 1) begin
              void'(mq[i].pop_front());
              mstart[i] = 1'b0;
              mpos[i]   = 0;
            end else begin
              mpos[i]++;
            end
          end
          if (sw_valid[i] && exp_rdy) begin
            mq[i].push_back(sw_data[i] & 13'((1 << w) - 1));
            macc[i]++;
          end
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if (mq[i].size() != 0) begin
        n_err++;
        $display("FAIL sweep_drain inst=%0d got %0d words left exp 0", i, mq[i].size());
      end
      n_chk++;
      if (mdone[i] != macc[i] - mabt[i]) begin
        n_err++;
        $display("FAIL sweep_done_count inst=%0d got %0d exp %0d (acc=%0d abt=%0d)",
                 i, mdone[i], macc[i] - mabt[i], macc[i], mabt[i]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_word();
    test_msb_first();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
